// File: rtl/jtbubl_linebuf_if.sv
// Port bundle for the sprite line buffer: draw-engine write side and
// pixel-rate scan-out side.
interface jtbubl_linebuf_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          pxl_cen;
  logic          LHBL;
  logic [8:0]    hdump;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_we;
  logic          enable;
  logic          ready;
  logic          swap;
  logic          bank;
  logic [DW-1:0] col_addr;

  modport slave (
    input  pxl_cen, LHBL, hdump, wr_addr, wr_data, wr_we, enable,
    output ready, swap, bank, col_addr
  );

  modport master (
    output pxl_cen, LHBL, hdump, wr_addr, wr_data, wr_we, enable,
    input  ready, swap, bank, col_addr
  );
endinterface

// File: rtl/jtbubl_linebuf.sv
// Double-buffered line buffer: the draw engine fills one bank while the other
// is scanned out at pixel rate and cleared right behind the read.
module jtbubl_linebuf #(
  parameter int unsigned   AW     = 8,
  parameter int unsigned   DW     = 8,
  parameter logic [3:0]    TRANSP = 4'hF,
  parameter logic [DW-1:0] CLR    = {DW{1'b1}}
) (
  input  logic            clk,
  input  logic            rst,
  jtbubl_linebuf_if.slave lb
);
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q;
  logic          init_c, run_c, cnt_last_c;
  logic          lhbl_l;
  logic          swap_c, cap_c, draw_we_c;
  logic          ready_q, swap_q, bank_q;
  logic [DW-1:0] col_q;
  logic          clr_we_q, clr_bank_q;
  logic [AW-1:0] clr_addr_q;
  logic [AW-1:0] rd_addr_c;
  logic [DW-1:0] q0, q1, rd_q_c;
  logic [1:0]    we_c;
  logic [AW-1:0] wa_c [2];
  logic [DW-1:0] wd_c [2];
  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  // Clearing sweep runs once per reset, then normal operation
  always_comb begin
    state_d = state_q;
    init_c  = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_c = 1'b1;
        if (cnt_last_c) state_d = ST_RUN;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  assign run_c      = (state_q == ST_RUN);
  assign cnt_last_c = (cnt_q == AW'(DEPTH - 1));
  assign rd_addr_c  = lb.hdump[AW-1:0];

  // Bank flips on the first blanked pixel of a line
  assign swap_c    = run_c & lb.pxl_cen & ~lb.LHBL & lhbl_l;
  // Only pixels actually shown on the visible line get erased
  assign cap_c     = run_c & lb.pxl_cen & lb.LHBL & ~lb.hdump[8];
  assign draw_we_c = run_c & lb.wr_we & (lb.wr_data[3:0] != TRANSP);
  assign rd_q_c    = bank_q ? q0 : q1;

  // Per-bank write port: sweep, then draw writes and trailing clears
  always_comb begin
    we_c = 2'b00;
    for (int b = 0; b < 2; b++) begin
      wa_c[b] = lb.wr_addr;
      wd_c[b] = lb.wr_data;
    end
    if (init_c) begin
      we_c = 2'b11;
      for (int b = 0; b < 2; b++) begin
        wa_c[b] = cnt_q;
        wd_c[b] = CLR;
      end
    end else begin
      if (draw_we_c) we_c[bank_q] = 1'b1;
      if (clr_we_q) begin
        we_c[clr_bank_q] = 1'b1;
        wa_c[clr_bank_q] = clr_addr_q;
        wd_c[clr_bank_q] = CLR;
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      swap_q     <= 1'b0;
      bank_q     <= 1'b0;
      col_q      <= CLR;
      lhbl_l     <= 1'b0;
      clr_we_q   <= 1'b0;
      clr_bank_q <= 1'b0;
      clr_addr_q <= '0;
    end else begin
      if (init_c) cnt_q <= cnt_q + AW'(1);
      ready_q  <= (state_d == ST_RUN);
      swap_q   <= swap_c;
      bank_q   <= bank_q ^ swap_c;
      if (lb.pxl_cen) lhbl_l <= lb.LHBL;
      if (run_c && lb.pxl_cen) col_q <= (lb.LHBL && lb.enable) ? rd_q_c : CLR;
      // Bank index travels with the address so a swap cannot redirect the clear
      clr_we_q <= cap_c;
      if (cap_c) begin
        clr_addr_q <= rd_addr_c;
        clr_bank_q <= ~bank_q;
      end
    end
  end

  // Bank 0 storage, synchronous read
  always_ff @(posedge clk) begin
    if (we_c[0]) mem0[wa_c[0]] <= wd_c[0];
    q0 <= mem0[rd_addr_c];
  end

  // Bank 1 storage, synchronous read
  always_ff @(posedge clk) begin
    if (we_c[1]) mem1[wa_c[1]] <= wd_c[1];
    q1 <= mem1[rd_addr_c];
  end

  assign lb.ready    = ready_q;
  assign lb.swap     = swap_q;
  assign lb.bank     = bank_q;
  assign lb.col_addr = col_q;
endmodule

// File: tb/tb_jtbubl_linebuf.sv
// Randomised bench for jtbubl_linebuf with a line-level reference model of
// two pixel banks.
module tb_jtbubl_linebuf;
  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 256;

  logic clk = 1'b0;
  logic rst;

  jtbubl_linebuf_if #(.AW(AW), .DW(DW)) lb_if ();

  jtbubl_linebuf #(.AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .lb  (lb_if)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: bank contents, write-bank pointer, last LHBL seen
  logic [7:0]  m_mem [2][DEPTH];
  bit          m_bank;
  bit          m_prev;
  bit          m_ready;
  logic [7:0]  m_col;
  logic [7:0]  seen [DEPTH];
  int unsigned wq_a[$];
  int unsigned wq_d[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[0][i] = 8'hFF;
      m_mem[1][i] = 8'hFF;
    end
    m_bank  = 1'b0;
    m_prev  = 1'b0;
    m_col   = 8'hFF;
    m_ready = 1'b0;
    wq_a.delete();
    wq_d.delete();
  endtask

  // Sweep period: garbage writes offered, all must be ignored
  task automatic wait_init();
    for (int i = 1; i <= 256; i++) begin
      lb_if.wr_we   = 1'b1;
      lb_if.wr_addr = 8'($urandom);
      lb_if.wr_data = 8'($urandom);
      tick();
      n_chk++;
      if (lb_if.ready !== 1'(i == 256) || lb_if.col_addr !== 8'hFF || lb_if.swap !== 1'b0)
        $display("FAIL init cyc=%0d ready=%b col=%h swap=%b required ready=%b col=ff swap=0",
                 i, lb_if.ready, lb_if.col_addr, lb_if.swap, 1'(i == 256));
      else n_pass++;
    end
    lb_if.wr_we = 1'b0;
    m_ready     = 1'b1;
  endtask

  // One pixel: 4 clk, pxl_cen on the third, write slot on the fourth
  task automatic pixel(input logic [8:0] h, input logic lhbl, input bit en,
                       input bit sw_we, input logic [7:0] sw_a, input logic [7:0] sw_d);
    logic [7:0] exp_col;
    bit         exp_swap;
    bit         rb;
    bit         we;
    logic [7:0] a, d;
    lb_if.hdump   = h;
    lb_if.LHBL    = lhbl;
    lb_if.enable  = en;
    lb_if.pxl_cen = 1'b0;
    tick();
    tick();
    n_chk++;
    if (lb_if.col_addr !== m_col)
      $display("FAIL hold h=%h col=%h required %h", h, lb_if.col_addr, m_col);
    else n_pass++;
    lb_if.pxl_cen = 1'b1;
    tick();
    lb_if.pxl_cen = 1'b0;
    rb       = !m_bank;
    exp_swap = m_prev && !lhbl;
    exp_col  = (lhbl && en) ? m_mem[rb][h[7:0]] : 8'hFF;
    if (lhbl && !h[8]) begin
      m_mem[rb][h[7:0]] = 8'hFF;
      seen[h[7:0]]      = lb_if.col_addr;
    end
    if (exp_swap) m_bank = !m_bank;
    m_prev = lhbl;
    m_col  = exp_col;
    n_chk++;
    if (lb_if.col_addr !== exp_col || lb_if.swap !== exp_swap || lb_if.bank !== m_bank)
      $display("FAIL pixel h=%h col=%h swap=%b bank=%b required col=%h swap=%b bank=%b",
               h, lb_if.col_addr, lb_if.swap, lb_if.bank, exp_col, exp_swap, m_bank);
    else n_pass++;
    we = 1'b0; a = 8'h00; d = 8'h00;
    if (sw_we) begin
      we = 1'b1; a = sw_a; d = sw_d;
    end else if (wq_a.size() > 0) begin
      we = 1'b1; a = 8'(wq_a.pop_front()); d = 8'(wq_d.pop_front());
    end
    lb_if.wr_we   = we;
    lb_if.wr_addr = a;
    lb_if.wr_data = d;
    tick();
    lb_if.wr_we = 1'b0;
    if (m_ready && we && d[3:0] != 4'hF) m_mem[m_bank][a] = d;
    n_chk++;
    if (lb_if.swap !== 1'b0)
      $display("FAIL swap_width h=%h swap=%b required 0", h, lb_if.swap);
    else n_pass++;
  endtask

  task automatic line(input int npx, input bit en, input bit sw_we,
                      input logic [7:0] sw_a, input logic [7:0] sw_d);
    for (int i = 0; i < DEPTH; i++) seen[i] = 8'h00;
    for (int i = 0; i < npx; i++) pixel(9'(i), 1'b1, en, 1'b0, 8'h00, 8'h00);
    pixel(9'h100, 1'b0, en, sw_we, sw_a, sw_d);
    for (int i = 1; i < 4; i++) pixel(9'h100 + 9'(i), 1'b0, en, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic push_wr(input int unsigned a, input int unsigned d);
    wq_a.push_back(a);
    wq_d.push_back(d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    model_reset();
    n_chk++;
    if (lb_if.ready !== 1'b0 || lb_if.col_addr !== 8'hFF || lb_if.bank !== 1'b0 || lb_if.swap !== 1'b0)
      $display("FAIL reset ready=%b col=%h bank=%b swap=%b required 0/ff/0/0",
               lb_if.ready, lb_if.col_addr, lb_if.bank, lb_if.swap);
    else n_pass++;
    rst = 1'b0;
    wait_init();
    line(256, 1'b1, 1'b0, 8'h00, 8'h00);
    line(256, 1'b1, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_basic();
    push_wr(10, 8'h23);
    line(32, 1'b1, 1'b0, 8'h00, 8'h00);
    line(32, 1'b1, 1'b0, 8'h00, 8'h00);
    n_chk++;
    if (seen[10] !== 8'h23 || seen[11] !== 8'hFF)
      $display("FAIL basic_read h10=%h h11=%h required 23/ff", seen[10], seen[11]);
    else n_pass++;
    line(32, 1'b1, 1'b0, 8'h00, 8'h00);
    line(32, 1'b1, 1'b0, 8'h00, 8'h00);
    n_chk++;
    if (seen[10] !== 8'hFF)
      $display("FAIL clear_after_read h10=%h required ff", seen[10]);
    else n_pass++;
  endtask

  task automatic test_transparent();
    push_wr(10, 8'h23);
    push_wr(10, 8'h4F);
    line(32, 1'b1, 1'b0, 8'h00, 8'h00);
    line(32, 1'b1, 1'b0, 8'h00, 8'h00);
    n_chk++;
    if (seen[10] !== 8'h23)
      $display("FAIL transparent h10=%h required 23", seen[10]);
    else n_pass++;
    push_wr(10, 8'h23);
    push_wr(10, 8'h51);
    line(32, 1'b1, 1'b0, 8'h00, 8'h00);
    line(32, 1'b1, 1'b0, 8'h00, 8'h00);
    n_chk++;
    if (seen[10] !== 8'h51)
      $display("FAIL overwrite h10=%h required 51", seen[10]);
    else n_pass++;
  endtask

  task automatic test_swap_write();
    line(32, 1'b1, 1'b1, 8'd20, 8'h12);
    line(32, 1'b1, 1'b0, 8'h00, 8'h00);
    n_chk++;
    if (seen[20] !== 8'hFF)
      $display("FAIL swap_write_early h20=%h required ff", seen[20]);
    else n_pass++;
    line(32, 1'b1, 1'b0, 8'h00, 8'h00);
    n_chk++;
    if (seen[20] !== 8'h12)
      $display("FAIL swap_write_late h20=%h required 12", seen[20]);
    else n_pass++;
  endtask

  task automatic test_enable();
    push_wr(5, 8'h33);
    line(32, 1'b1, 1'b0, 8'h00, 8'h00);
    line(32, 1'b0, 1'b0, 8'h00, 8'h00);
    n_chk++;
    if (seen[5] !== 8'hFF)
      $display("FAIL enable_off h5=%h required ff", seen[5]);
    else n_pass++;
    line(32, 1'b1, 1'b0, 8'h00, 8'h00);
    line(32, 1'b1, 1'b0, 8'h00, 8'h00);
    n_chk++;
    if (seen[5] !== 8'hFF)
      $display("FAIL enable_off_cleared h5=%h required ff", seen[5]);
    else n_pass++;
  endtask

  task automatic test_random();
    int unsigned nw;
    logic [7:0]  d;
    bit          en;
    for (int l = 0; l < 8; l++) begin
      nw = $urandom_range(0, 30);
      for (int k = 0; k < int'(nw); k++) begin
        d = 8'($urandom);
        if ($urandom_range(0, 3) == 0) d[3:0] = 4'hF;
        push_wr($urandom_range(0, 39), d);
      end
      en = ($urandom_range(0, 4) != 0);
      line(32, en, ($urandom_range(0, 1) == 1), 8'($urandom_range(0, 39)), 8'($urandom));
    end
  endtask

  task automatic test_reset_midline();
    push_wr(3, 8'hA1);
    push_wr(7, 8'hB2);
    line(32, 1'b1, 1'b0, 8'h00, 8'h00);
    push_wr(12, 8'hC3);
    for (int i = 0; i < 5; i++) pixel(9'(i), 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    tick();
    model_reset();
    n_chk++;
    if (lb_if.ready !== 1'b0 || lb_if.col_addr !== 8'hFF || lb_if.bank !== 1'b0 || lb_if.swap !== 1'b0)
      $display("FAIL midline_reset ready=%b col=%h bank=%b swap=%b required 0/ff/0/0",
               lb_if.ready, lb_if.col_addr, lb_if.bank, lb_if.swap);
    else n_pass++;
    rst = 1'b0;
    wait_init();
    line(256, 1'b1, 1'b0, 8'h00, 8'h00);
    line(256, 1'b1, 1'b0, 8'h00, 8'h00);
    n_chk++;
    if (seen[3] !== 8'hFF || seen[7] !== 8'hFF || seen[12] !== 8'hFF)
      $display("FAIL midline_wipe h3=%h h7=%h h12=%h required ff", seen[3], seen[7], seen[12]);
    else n_pass++;
  endtask

  initial begin
    rst           = 1'b1;
    lb_if.pxl_cen = 1'b0;
    lb_if.LHBL    = 1'b0;
    lb_if.hdump   = 9'h000;
    lb_if.wr_addr = 8'h00;
    lb_if.wr_data = 8'h00;
    lb_if.wr_we   = 1'b0;
    lb_if.enable  = 1'b1;
    test_reset();
    test_basic();
    test_transparent();
    test_swap_write();
    test_enable();
    test_random();
    test_reset_midline();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
